fmul_round_stage: RTL

Normalize-and-round back end for the single-precision multiplier datapath. It consumes the raw sign, biased-exponent sum and full 48-bit significand product from the multiply stage. It produces a correctly rounded IEEE-754 binary32 result (round-to-nearest-even, subnormals flushed to zero) with exception flags. It is a 2-stage valid/ready pipeline that sustains one result per cycle under backpressure.

---
 rtl/fmul_round_stage.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fmul_round_stage.sv
// fmul_round_stage: normalize-and-round back end of the binary32 multiplier.
// Stage 1 normalizes the 48-bit significand product and classifies specials;
// stage 2 rounds to nearest-even, flushes subnormals and packs the result.
// Two-deep valid/ready pipeline with a combinational ready chain, so a full
// pipeline can accept and drain in the same cycle without a bubble.
module fmul_round_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [47:0] in_mant,
    input  logic        in_zero,
    input  logic        in_inf,
    input  logic        in_nan,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_z,
    output logic [2:0]  out_flags
);

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_ZERO   = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } cls_e;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_q;
    logic out_valid_q;
    logic s1_en;
    logic s2_en;

    assign s2_en    = !out_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en;

    // ------------------------------------------------------------------
    // Stage 1: normalize and classify
    // ------------------------------------------------------------------
    logic               norm;
    logic [22:0]        s1_frac_d;
    logic               s1_g_d;
    logic               s1_s_d;
    logic signed [10:0] s1_e_d;
    cls_e               s1_cls_d;

    logic               s1_sign_q;
    logic signed [10:0] s1_e_q;
    logic [22:0]        s1_frac_q;
    logic               s1_g_q;
    logic               s1_s_q;
    cls_e               s1_cls_q;

    // Select the 23 fraction bits, guard and sticky for either leading-one position.
    always_comb begin
        norm      = in_mant[47];
        s1_frac_d = norm ? in_mant[46:24] : in_mant[45:23];
        s1_g_d    = norm ? in_mant[23]    : in_mant[22];
        s1_s_d    = norm ? (|in_mant[22:0]) : (|in_mant[21:0]);
        // Exponent sum carries two biases; remove one and add the normalize shift.
        s1_e_d    = $signed({1'b0, in_exp} - 11'd127 + {10'd0, norm});
        if (in_nan) begin
            s1_cls_d = CLS_NAN;
        end else if (in_inf) begin
            s1_cls_d = CLS_INF;
        end else if (in_zero) begin
            s1_cls_d = CLS_ZERO;
        end else begin
            s1_cls_d = CLS_NORMAL;
        end
    end

    // Stage 1 valid tracks accepted beats; it advances whenever stage 2 can take the held beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
        end else if (s1_en) begin
            s1_valid_q <= in_valid;
        end
    end

    // Stage 1 payload is captured only on an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sign_q <= 1'b0;
            s1_e_q    <= '0;
            s1_frac_q <= '0;
            s1_g_q    <= 1'b0;
            s1_s_q    <= 1'b0;
            s1_cls_q  <= CLS_NORMAL;
        end else if (s1_en && in_valid) begin
            s1_sign_q <= in_sign;
            s1_e_q    <= s1_e_d;
            s1_frac_q <= s1_frac_d;
            s1_g_q    <= s1_g_d;
            s1_s_q    <= s1_s_d;
            s1_cls_q  <= s1_cls_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round to nearest-even, range check, pack
    // ------------------------------------------------------------------
    logic               round_up;
    logic [23:0]        frac_sum;
    logic               carry;
    logic [22:0]        frac_rnd;
    logic signed [10:0] e_rnd;
    logic               ovf;
    logic               unf;
    logic [31:0]        out_z_d;
    logic [2:0]         out_flags_d;
    logic [31:0]        out_z_q;
    logic [2:0]         out_flags_q;

    // Rounding and packing; range checks use the exponent after the rounding carry.
    always_comb begin
        round_up = s1_g_q & (s1_s_q | s1_frac_q[0]);
        frac_sum = {1'b0, s1_frac_q} + {23'd0, round_up};
        carry    = frac_sum[23];
        frac_rnd = carry ? 23'd0 : frac_sum[22:0];
        e_rnd    = s1_e_q + $signed({10'd0, carry});
        ovf      = (e_rnd >= 11'sd255);
        unf      = (e_rnd <= 11'sd0);

        out_z_d     = '0;
        out_flags_d = '0;
        unique case (s1_cls_q)
            CLS_NAN: begin
                out_z_d = QNAN;
            end
            CLS_INF: begin
                out_z_d = {s1_sign_q, 8'hFF, 23'd0};
            end
            CLS_ZERO: begin
                out_z_d = {s1_sign_q, 31'd0};
            end
            default: begin
                if (ovf) begin
                    out_z_d     = {s1_sign_q, 8'hFF, 23'd0};
                    out_flags_d = 3'b101;
                end else if (unf) begin
                    // Subnormal results are flushed to a signed zero.
                    out_z_d     = {s1_sign_q, 31'd0};
                    out_flags_d = 3'b011;
                end else begin
                    out_z_d     = {s1_sign_q, e_rnd[7:0], frac_rnd};
                    out_flags_d = {2'b00, s1_g_q | s1_s_q};
                end
            end
        endcase
    end

    // Output valid follows stage 1 whenever the output register may be overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else if (s2_en) begin
            out_valid_q <= s1_valid_q;
        end
    end

    // Output payload loads only with a real beat, so it holds steady under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_z_q     <= '0;
            out_flags_q <= '0;
        end else if (s2_en && s1_valid_q) begin
            out_z_q     <= out_z_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_z     = out_z_q;
    assign out_flags = out_flags_q;

endmodule
